system_pio_out: RTL and testbench
=================================

// Module: system_pio_out
// PURPOSE
//  Parametrised Avalon-MM output PIO for the system interconnect; drives WIDTH general-purpose outputs.
//  Adds atomic bit-set and bit-clear registers and a timed one-shot pulse overlay.
//  Sits on the CPU data master as a zero-wait-state, read-latency-0 slave.
// PARAMETERS
//  WIDTH       8     output port width, 1..32
//  RESET_VALUE 0     value loaded into DATA on reset; WIDTH bits
//  PULSE_LEN   16    pulse duration in clk cycles, 1..65535
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  address     in   3      register word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe, qualified by chipselect
//  writedata   in   32     write data; only bits [WIDTH-1:0] are used
//  readdata    out  32     read data, combinational from address; zero-extended
//  out_port    out  WIDTH  output pins
// BEHAVIOUR
//  - Single clock is clk; reset is synchronous and active-high. No other clocks or resets.
//  - Write strobe: wr = chipselect & ~write_n. All register updates occur on the clk edge where wr=1.
//  - Register map (address -> write effect / read value):
//    0 DATA   : data <= wd[WIDTH-1:0]                  / data
//    1,2,3    : ignored                                / 0
//    4 SET    : data <= data | wd                      / 0
//    5 CLEAR  : data <= data & ~wd                     / 0
//    6 PULSE  : mask <= wd; cnt <= (wd!=0)?PULSE_LEN:0 / {cnt, zero-extended}
//    7 STATUS : ignored                                / {31'b0, busy}
//  - busy = (cnt != 0). cnt width is clog2(PULSE_LEN+1).
//  - cnt decrements by 1 on every edge where busy=1 and no PULSE write occurs. It saturates at 0.
//  - On the edge where cnt goes 1->0, mask is cleared to 0.
//  - out_port = data | (busy ? mask : 0). Both terms come from registers, so there is no combinational path from writedata.
//  - Latency: a write at edge N is visible on out_port and readdata after edge N.
//  - A PULSE write with nonzero wd asserts the masked bits for exactly PULSE_LEN cycles.
//  - A PULSE write while busy replaces the mask and restarts cnt at PULSE_LEN. There is no accumulation.
//  - A PULSE write with wd=0 cancels immediately: mask=0, cnt=0, busy=0 after the edge.
//  - DATA, SET and CLEAR writes while busy change data only. The pulse keeps running.
//  - A bit set in both data and mask stays high after the pulse ends.
//  - Reset, including mid-pulse: data=RESET_VALUE, mask=0, cnt=0, busy=0.
//    out_port=RESET_VALUE and readdata reflects the reset state on the following cycle.
//  - readdata bits [31:WIDTH] are always 0. The read path has no side effects.
// CONFIGURATION
//  - SYSTEM_PIO_PULSE_EN defined:
//    mask, cnt and the PULSE/STATUS registers are built as described above.
//  - SYSTEM_PIO_PULSE_EN undefined:
//    mask and cnt are not instantiated; addresses 6 and 7 read 0 and ignore writes.
//    out_port = data; SET and CLEAR are still present.
// TESTING
//  - Reset: assert reset 2 cycles with RESET_VALUE=8'hA5 -> out_port=8'hA5, read addr7=0, read addr6=0.
//  - DATA/SET/CLEAR sequence:
//    write addr0=8'h0F, then addr4=8'h30, then addr5=8'h05 -> out_port 8'h0F, 8'h3F, 8'h3A after successive edges.
//    Read addr0=32'h3A.
//  - Pulse timing: data=0, write addr6=8'h81 with PULSE_LEN=16.
//    -> out_port=8'h81 for exactly 16 cycles, then 8'h00.
//    Read addr6 immediately after the write = 16; addr7 reads 1 while busy and 0 after.
//  - Retrigger and cancel:
//    write addr6=8'h01; after 10 cycles write addr6=8'h02 -> bit0 drops, bit1 high for 16 cycles.
//    Write addr6=0 mid-pulse -> out_port returns to data on the next cycle.
//  - Overlap and reset: start a pulse with mask 8'hFF.
//    Write addr0=8'h0C mid-pulse -> out_port stays 8'hFF until the pulse ends, then 8'h0C.
//    Assert reset mid-pulse -> out_port=RESET_VALUE and busy=0 on the next edge.
//  - Macro off and width: build without SYSTEM_PIO_PULSE_EN and with WIDTH=32.
//    Write addr6 -> no out_port change, addr6/addr7 read 0.
//    Write addr0=32'hDEADBEEF -> readdata=32'hDEADBEEF.

Source files
------------

// File: rtl/system_pio_out.sv
// Avalon-MM output PIO with atomic set/clear registers and an optional timed pulse overlay.
// Define SYSTEM_PIO_PULSE_EN to build the PULSE (addr 6) and STATUS (addr 7) registers.
`timescale 1ns/1ps

module system_pio_out #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_LEN   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE  = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data;
  logic             unused_writedata;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  // Output data register with atomic read-modify-write aliases.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        ADDR_DATA:  data <= wd;
        ADDR_SET:   data <= data | wd;
        ADDR_CLEAR: data <= data & ~wd;
        default:    ;
      endcase
    end
  end

`ifdef SYSTEM_PIO_PULSE_EN
  localparam int CNT_W = $clog2(PULSE_LEN + 1);

  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] cnt;
  logic             busy;

  assign busy = (cnt != '0);

  // A PULSE write always wins over the countdown: it restarts or cancels the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      cnt  <= '0;
    end else if (wr && (address == ADDR_PULSE)) begin
      mask <= wd;
      cnt  <= (wd != '0) ? CNT_W'(PULSE_LEN) : '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        mask <= '0;
      end
    end
  end

  assign out_port = data | (busy ? mask : '0);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0] = data;
      ADDR_PULSE:  readdata[CNT_W-1:0] = cnt;
      ADDR_STATUS: readdata[0]         = busy;
      default:     readdata            = '0;
    endcase
  end
`else
  assign out_port = data;

  always_comb begin
    readdata = '0;
    if (address == ADDR_DATA) begin
      readdata[WIDTH-1:0] = data;
    end
  end
`endif

endmodule

// File: tb/tb_system_pio_out.sv
// Self-checking bench for system_pio_out: directed vectors, pulse corner cases and random traffic
// against a cycle-count based reference model.
`timescale 1ns/1ps

module tb_system_pio_out;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'hA5;
  localparam int         PL    = 16;
`ifdef SYSTEM_PIO_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  logic [2:0]  w_address;
  logic        w_chipselect;
  logic        w_write_n;
  logic [31:0] w_writedata;
  logic [31:0] w_readdata;
  logic [31:0] w_out_port;

  int checks   = 0;
  int failures = 0;

  // Reference model: pulse is described by the cycle number at which it ends.
  int         cyc;
  logic [7:0] m_data;
  logic [7:0] m_mask;
  int         m_end;

  always #5 clk = ~clk;

  system_pio_out #(.WIDTH(WIDTH), .RESET_VALUE(RV), .PULSE_LEN(PL)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
  );

  system_pio_out #(.WIDTH(32), .RESET_VALUE(32'h0), .PULSE_LEN(PL)) dut_wide (
    .clk(clk), .reset(reset), .address(w_address), .chipselect(w_chipselect),
    .write_n(w_write_n), .writedata(w_writedata), .readdata(w_readdata), .out_port(w_out_port)
  );

  function automatic logic [31:0] model_out();
    return {24'b0, m_data | ((cyc < m_end) ? m_mask : 8'h00)};
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      3'd0: r = {24'b0, m_data};
      3'd6: if (PULSE_EN && cyc < m_end) r = 32'(m_end - cyc);
      3'd7: if (PULSE_EN && cyc < m_end) r = 32'd1;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock edge with the given bus cycle on the narrow DUT; the model follows the same edge.
  task automatic applyStimulus(input logic rst, input logic cs, input logic wn,
                               input logic [2:0] a, input logic [31:0] d);
    reset      = rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_data = RV;
      m_mask = '0;
      m_end  = cyc;
    end else if (cs && !wn) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd4: m_data = m_data | d[7:0];
        3'd5: m_data = m_data & ~d[7:0];
        3'd6: if (PULSE_EN) begin
          m_mask = d[7:0];
          m_end  = (d[7:0] != 8'h00) ? cyc + PL : cyc;
        end
        default: ;
      endcase
    end
    #1;
    reset        = 1'b0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    w_chipselect = 1'b0;
    w_write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic readCheck(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    checkOutput(name, readdata, exp);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  exp_out;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #400000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    cyc = 0; m_data = RV; m_mask = '0; m_end = 0;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    w_address = '0; w_chipselect = 1'b0; w_write_n = 1'b1; w_writedata = '0;

    vecs[0] = '{3'd0, 32'h0000_000F, 8'h0F};
    vecs[1] = '{3'd4, 32'h0000_0030, 8'h3F};
    vecs[2] = '{3'd5, 32'h0000_0005, 8'h3A};
    vecs[3] = '{3'd4, 32'hFFFF_FF80, 8'hBA};
    vecs[4] = '{3'd2, 32'h0000_0055, 8'hBA};
    vecs[5] = '{3'd5, 32'h0000_00F0, 8'h0A};
    vecs[6] = '{3'd0, 32'hFFFF_FF00, 8'h00};

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    checkOutput("reset_out", {24'b0, out_port}, 32'h0000_00A5);
    readCheck("reset_rd7", 3'd7, 32'h0);
    readCheck("reset_rd6", 3'd6, 32'h0);
    readCheck("reset_rd0", 3'd0, 32'h0000_00A5);

    // DATA / SET / CLEAR table
    for (int i = 0; i < 7; i++) begin
      writeReg(vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d_out", i), {24'b0, out_port}, {24'b0, vecs[i].exp_out});
      if (i == 2) readCheck("vec_rd0", 3'd0, 32'h0000_003A);
    end
    writeReg(3'd0, 32'hFFFF_FFFF);
    readCheck("rd0_zero_ext", 3'd0, 32'h0000_00FF);
    readCheck("rd1_zero", 3'd1, 32'h0);
    readCheck("rd4_zero", 3'd4, 32'h0);
    writeReg(3'd0, 32'h0);

    // Pulse timing
    writeReg(3'd6, 32'h81);
    readCheck("pulse_rd6", 3'd6, PULSE_EN ? 32'd16 : 32'd0);
    for (int i = 0; i < PL; i++) begin
      checkOutput("pulse_out", {24'b0, out_port}, PULSE_EN ? 32'h81 : 32'h0);
      readCheck("pulse_busy", 3'd7, PULSE_EN ? 32'd1 : 32'd0);
      idle(1);
    end
    checkOutput("pulse_end_out", {24'b0, out_port}, 32'h0);
    readCheck("pulse_end_busy", 3'd7, 32'h0);

    // Retrigger, then cancel
    writeReg(3'd6, 32'h01);
    idle(9);
    checkOutput("retrig_pre", {24'b0, out_port}, PULSE_EN ? 32'h01 : 32'h0);
    writeReg(3'd6, 32'h02);
    for (int i = 0; i < PL; i++) begin
      checkOutput("retrig_out", {24'b0, out_port}, PULSE_EN ? 32'h02 : 32'h0);
      idle(1);
    end
    checkOutput("retrig_end", {24'b0, out_port}, 32'h0);
    writeReg(3'd0, 32'h10);
    writeReg(3'd6, 32'h01);
    idle(3);
    writeReg(3'd6, 32'h0);
    checkOutput("cancel_out", {24'b0, out_port}, 32'h10);
    readCheck("cancel_busy", 3'd7, 32'h0);
    writeReg(3'd0, 32'h0);

    // Overlap with data write, then reset mid-pulse
    writeReg(3'd6, 32'hFF);
    idle(2);
    writeReg(3'd0, 32'h0C);
    for (int i = 0; i < 13; i++) begin
      checkOutput("overlap_out", {24'b0, out_port}, PULSE_EN ? 32'hFF : 32'h0C);
      idle(1);
    end
    checkOutput("overlap_end", {24'b0, out_port}, 32'h0C);
    writeReg(3'd6, 32'hFF);
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 32'h0);
    checkOutput("rst_mid_out", {24'b0, out_port}, 32'h0000_00A5);
    readCheck("rst_mid_busy", 3'd7, 32'h0);
    readCheck("rst_mid_cnt", 3'd6, 32'h0);
    idle(1);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic        rst, cs, wn;
      logic [2:0]  a;
      logic [31:0] d;
      rst = ($urandom_range(0, 99) < 2);
      cs  = ($urandom_range(0, 3) != 0);
      wn  = ($urandom_range(0, 3) == 0);
      a   = 3'($urandom_range(0, 7));
      d   = $urandom;
      if ($urandom_range(0, 3) == 0) d[7:0] = 8'h00;
      applyStimulus(rst, cs, wn, a, d);
      checkOutput("rand_out", {24'b0, out_port}, model_out());
      a = 3'($urandom_range(0, 7));
      readCheck($sformatf("rand_rd%0d", a), a, model_read(a));
    end

    // Full-width instance
    w_address = 3'd6; w_chipselect = 1'b1; w_write_n = 1'b0; w_writedata = 32'h0000_00F0;
    idle(1);
    checkOutput("wide_pulse_out", w_out_port, PULSE_EN ? 32'h0000_00F0 : 32'h0);
    w_address = 3'd6; #1;
    checkOutput("wide_rd6", w_readdata, PULSE_EN ? 32'd16 : 32'd0);
    w_address = 3'd7; #1;
    checkOutput("wide_rd7", w_readdata, PULSE_EN ? 32'd1 : 32'd0);
    w_address = 3'd0; w_chipselect = 1'b1; w_write_n = 1'b0; w_writedata = 32'hDEAD_BEEF;
    idle(1);
    checkOutput("wide_out", w_out_port, PULSE_EN ? 32'hDEAD_BEFF : 32'hDEAD_BEEF);
    w_address = 3'd0; #1;
    checkOutput("wide_rd0", w_readdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
